// File: rtl/cache_1_pkg.sv
// Shared definitions for the level-1 direct-mapped cache controller:
// FSM state encoding and the tag-width helper.
package cache_1_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_MEM_RD = 2'd2;
    localparam logic [1:0] ST_MEM_WR = 2'd3;

    function automatic int tag_w(input int addr_width, input int index_width);
        return addr_width - index_width;
    endfunction

endpackage

// File: rtl/cache_1_data.sv
// Synchronous-read data array: the read address is registered, so data_out
// reflects the address presented on the previous clock edge.
module cache_1_data #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic [AWIDTH-1:0] addr,
    input  logic              write_enable,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [AWIDTH-1:0] raddr_q;

    always_ff @(posedge clock) begin
        raddr_q <= addr;
        if (write_enable) begin
            mem_q[addr] <= data_in;
        end
    end

    assign data_out = mem_q[raddr_q];

endmodule

// File: rtl/cache_1_tag.sv
// Valid/tag register file: combinational lookup port, synchronous write port.
// Only the valid bits are cleared by reset; stale tags are masked by valid.
module cache_1_tag
    import cache_1_pkg::*;
#(
    parameter int INDEX_WIDTH = 3,
    parameter int TAG_W       = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_W-1:0]       wr_tag
);

    logic [2**INDEX_WIDTH-1:0] valid_q;
    logic [TAG_W-1:0]          tag_q [2**INDEX_WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/cache_1_ctrl.sv
// Level-1 direct-mapped cache controller: tag lookup, refill on read miss,
// write-through / no-write-allocate, saturating hit and miss counters.
module cache_1_ctrl
    import cache_1_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic                  cpu_hit,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    localparam int TAG_W = tag_w(ADDR_WIDTH, INDEX_WIDTH);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  hit_q, hit_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  done_q, done_d;
    logic                  cpu_hit_q, cpu_hit_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       tag;
    logic                   lk_valid;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lookup_hit;
    logic                   refill;
    logic [INDEX_WIDTH-1:0] arr_addr;
    logic                   arr_we;
    logic [DATA_WIDTH-1:0]  arr_din;
    logic [DATA_WIDTH-1:0]  arr_dout;

    assign idx        = addr_q[INDEX_WIDTH-1:0];
    assign tag        = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign lookup_hit = lk_valid && (lk_tag == tag);
    assign refill     = (state_q == ST_MEM_RD) && mem_ack;

    // IDLE presents the incoming index so array data is ready during LOOKUP.
    assign arr_addr = (state_q == ST_IDLE) ? cpu_addr[INDEX_WIDTH-1:0] : idx;
    assign arr_we   = ((state_q == ST_LOOKUP) && we_q && lookup_hit) || refill;
    assign arr_din  = (state_q == ST_MEM_RD) ? mem_rdata : wdata_q;

    cache_1_tag #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_W       (TAG_W)
    ) u_tag (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_valid (lk_valid),
        .rd_tag   (lk_tag),
        .wr_en    (refill),
        .wr_idx   (idx),
        .wr_tag   (tag)
    );

    cache_1_data #(
        .AWIDTH (INDEX_WIDTH),
        .DWIDTH (DATA_WIDTH)
    ) u_data (
        .clock        (clock),
        .addr         (arr_addr),
        .write_enable (arr_we),
        .data_in      (arr_din),
        .data_out     (arr_dout)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hit_d      = hit_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        done_d     = 1'b0;
        cpu_hit_d  = 1'b0;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d = lookup_hit;
                if (lookup_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
                else            miss_cnt_d = sat_inc(miss_cnt_q);
                if (we_q) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    state_d   = ST_MEM_WR;
                end else if (lookup_hit) begin
                    done_d    = 1'b1;
                    cpu_hit_d = 1'b1;
                    rdata_d   = arr_dout;
                    state_d   = ST_IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    state_d   = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = mem_rdata;
                    state_d   = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    cpu_hit_d = hit_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            cpu_hit_q  <= 1'b0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hit_q      <= hit_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            done_q     <= done_d;
            cpu_hit_q  <= cpu_hit_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign cpu_ready = (state_q == ST_IDLE);
    assign cpu_done  = done_q;
    assign cpu_hit   = cpu_hit_q;
    assign cpu_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_1_ctrl.sv
// Bench for cache_1_ctrl: directed vector table, reset-abort sequence and
// random traffic against a cache/memory reference model.
module tb_cache_1_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_done, cpu_hit;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt, miss_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    cache_1_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Reference model: backing memory plus cache line state.
    logic [31:0] mainmem [256];
    logic        mv [8];
    logic [4:0]  mt [8];
    logic [31:0] md [8];
    int          m_hits, m_misses;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          dly;
        logic        exp_hit;
        logic [31:0] exp_rdata;
        logic        exp_mem;
        int          exp_h;
        int          exp_m;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    // Runs one CPU transaction starting at a negedge; returns at a negedge.
    task automatic txn(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input int dly, input logic idle_after,
                       output logic got_hit, output logic [31:0] got_rdata, output logic got_mem);
        int n, done_n, req_n, ack_n;
        logic stray;
        logic ehit, emem;
        logic [31:0] erd;
        logic [2:0] idx;
        idx  = addr[2:0];
        ehit = mv[idx] && (mt[idx] == addr[7:3]);
        erd  = ehit ? md[idx] : mainmem[addr];
        emem = we || !ehit;

        chk("ready", cpu_ready, 1);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        cpu_we = $urandom_range(0, 1); cpu_addr = 8'($urandom); cpu_wdata = $urandom;
        n = 1; done_n = -1; req_n = -1; ack_n = -1; stray = 1'b0;
        while (n < 40 && done_n < 0) begin
            mem_ack = 1'b0;
            if (cpu_done) begin
                done_n = n;
            end else begin
                if (cpu_hit) stray = 1'b1;
                if (mem_req && ack_n < 0) begin
                    if (req_n < 0) begin
                        req_n = n;
                        chk("mem_addr", mem_addr, addr);
                        chk("mem_we", mem_we, we);
                        if (we) chk("mem_wdata", mem_wdata, wd);
                    end
                    if (n - req_n == dly) begin
                        mem_ack = 1'b1;
                        mem_rdata = we ? $urandom : mainmem[addr];
                        ack_n = n;
                    end
                end
                @(negedge clock);
                n++;
            end
        end
        mem_ack = 1'b0;
        got_hit = cpu_hit;
        got_rdata = cpu_rdata;
        got_mem = (req_n >= 0);

        chk("done_cycle", done_n, emem ? ack_n + 1 : 2);
        chk("hit", cpu_hit, ehit);
        if (!we) chk("rdata", cpu_rdata, erd);
        chk("mem_used", got_mem, emem);
        if (emem) chk("req_cycle", req_n, 2);
        chk("req_drop", mem_req, 0);
        chk("hit_idle", stray, 0);

        if (ehit) m_hits++; else m_misses++;
        if (we) begin
            mainmem[addr] = wd;
            if (ehit) md[idx] = wd;
        end else if (!ehit) begin
            mv[idx] = 1'b1; mt[idx] = addr[7:3]; md[idx] = mainmem[addr];
        end
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);

        if (idle_after) begin
            @(negedge clock);
            chk("done_pulse", cpu_done, 0);
            chk("hit_hold0", cpu_hit, 0);
            chk("rdata_hold", cpu_rdata, got_rdata);
        end
    endtask

    initial begin
        logic h, m;
        logic [31:0] rd;
        int k;

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < 256; i++) mainmem[i] = $urandom;
        mainmem[8'h15] = 32'hDEADBEEF;
        mainmem[8'h0D] = 32'hAAAA0D0D;
        model_reset();

        vecs[0] = '{1'b0, 8'h15, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1'b1, 0, 1};
        vecs[1] = '{1'b0, 8'h15, 32'h0,        1, 1'b1, 32'hDEADBEEF, 1'b0, 1, 1};
        vecs[2] = '{1'b1, 8'h15, 32'h12345678, 1, 1'b1, 32'h0,        1'b1, 2, 1};
        vecs[3] = '{1'b0, 8'h15, 32'h0,        1, 1'b1, 32'h12345678, 1'b0, 3, 1};
        vecs[4] = '{1'b0, 8'h0D, 32'h0,        0, 1'b0, 32'hAAAA0D0D, 1'b1, 3, 2};
        vecs[5] = '{1'b0, 8'h15, 32'h0,        2, 1'b0, 32'h12345678, 1'b1, 3, 3};
        vecs[6] = '{1'b1, 8'h22, 32'hCAFEF00D, 1, 1'b0, 32'h0,        1'b1, 3, 4};
        vecs[7] = '{1'b0, 8'h22, 32'h0,        0, 1'b0, 32'hCAFEF00D, 1'b1, 3, 5};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", cpu_ready, 1);
        chk("rst_done", cpu_done, 0);
        chk("rst_hit", cpu_hit, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_memwe", mem_we, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_memwdata", mem_wdata, 0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 0);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dly, 1'b1, h, rd, m);
            chk($sformatf("vec%0d_hit", i), h, vecs[i].exp_hit);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_mem", i), m, vecs[i].exp_mem);
            chk($sformatf("vec%0d_cnts", i), {hit_cnt, miss_cnt}, {16'(vecs[i].exp_h), 16'(vecs[i].exp_m)});
        end

        // Stray ack while idle must be ignored.
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        chk("stray_ack_done", cpu_done, 0);
        chk("stray_ack_req", mem_req, 0);

        for (int i = 0; i < 150; i++) begin
            txn($urandom_range(0, 9) < 3, 8'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 1), h, rd, m);
        end

        // Reset while waiting for a refill, followed by a late ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h3A;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("abort_req_seen", mem_req, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_req_drop", mem_req, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clock);
        mem_ack = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            if (cpu_done) k++;
            @(negedge clock);
        end
        chk("abort_no_done", k, 0);
        chk("abort_req", mem_req, 0);
        chk("abort_cnts", {hit_cnt, miss_cnt}, 0);
        model_reset();
        txn(1'b0, 8'h15, 32'h0, 1, 1'b1, h, rd, m);
        chk("abort_refetch_hit", h, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_1_ctrl.md
Name: cache_1_ctrl

Overview:
Controller for the level-1 direct-mapped data cache. It accepts single-word CPU read/write requests and performs the tag lookup. It sequences the synchronous-read data array `cache_1_data`, which has a registered read address and returns data one cycle after the address is presented. Read misses fetch from the next-level memory over a req/ack handshake. Writes are write-through / no-write-allocate. The block also keeps saturating hit and miss counters.

Parameters:
ADDR_WIDTH, 8, CPU word-address width.
INDEX_WIDTH, 3, line index width; equals the data array AWIDTH (8 lines).
DATA_WIDTH, 32, word width; equals the data array DWIDTH.
CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  request valid; sampled only while cpu_ready=1.
cpu_we  in  1  1=write, 0=read; qualified by cpu_req.
cpu_addr  in  ADDR_WIDTH  word address; index=[INDEX_WIDTH-1:0], tag=upper bits.
cpu_wdata  in  DATA_WIDTH  write data.
cpu_ready  out  1  high only in IDLE.
cpu_done  out  1  one-cycle completion pulse (registered).
cpu_hit  out  1  valid with cpu_done; 1=request hit.
cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_done for reads (registered).
mem_req  out  1  next-level request; held until mem_ack.
mem_we  out  1  next-level write/read select.
mem_addr  out  ADDR_WIDTH  next-level address (latched cpu_addr).
mem_wdata  out  DATA_WIDTH  next-level write data (latched cpu_wdata).
mem_rdata  in  DATA_WIDTH  next-level read data, valid with mem_ack.
mem_ack  in  1  next-level completion, one-cycle pulse.
hit_cnt  out  CNT_WIDTH  saturating count of hits.
miss_cnt  out  CNT_WIDTH  saturating count of misses.

Behaviour:
- Reset: state=IDLE; all valid bits=0; cpu_done=0, cpu_hit=0, cpu_rdata=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; hit_cnt=miss_cnt=0. Data array contents are not cleared; validity alone governs hits.
- States and transitions:
  - IDLE -> LOOKUP on cpu_req. Latch addr/we/wdata. Array addr is driven combinationally from the cpu_addr index in IDLE and from the latched index otherwise.
  - LOOKUP, read hit (valid[idx] && tag match) -> IDLE. Register cpu_done=1, cpu_hit=1, cpu_rdata=array data_out.
  - LOOKUP, read miss -> MEM_RD. Set mem_req=1, mem_we=0.
  - LOOKUP, write -> MEM_WR. Set mem_req=1, mem_we=1. On a write hit, assert array write_enable with cpu_wdata in this LOOKUP cycle. A write miss leaves the array and tags untouched.
  - MEM_RD, on mem_ack -> IDLE. Write mem_rdata into array[idx]; set valid[idx]=1 and tag[idx]=tag. Clear mem_req. Register cpu_done=1, cpu_hit=0, cpu_rdata=mem_rdata.
  - MEM_WR, on mem_ack -> IDLE. Clear mem_req. Register cpu_done=1, cpu_hit=the hit result from LOOKUP.
- Latency, with C = acceptance cycle:
  - Read hit: cpu_done in C+2.
  - Misses and all writes: mem_req rises in C+2; cpu_done in K+1, where K is the mem_ack cycle.
  - cpu_ready is high again in the cycle cpu_done is high, so back-to-back requests are allowed.
- mem_ack may arrive in the first cycle mem_req is high. mem_ack outside MEM_RD/MEM_WR is ignored.
- Counters: the LOOKUP outcome increments hit_cnt or miss_cnt by 1, for both reads and writes. Each counter saturates at all-ones.
- Reset mid-transaction aborts the transaction: no cpu_done is issued, mem_req drops the next cycle, and a late mem_ack is ignored.
- cpu_rdata holds its last value when cpu_done=0. cpu_hit is 0 when cpu_done=0.

Decomposition:
- Package cache_1_pkg: state encoding (IDLE, LOOKUP, MEM_RD, MEM_WR) and the tag-width function TAG_W = ADDR_WIDTH-INDEX_WIDTH.
- Sub-module cache_1_tag: valid and tag register file, 2^INDEX_WIDTH entries, with a combinational lookup port, a synchronous write port, and synchronous valid clear on reset.
- The data array is instantiated as cache_1_data with AWIDTH=INDEX_WIDTH and DWIDTH=DATA_WIDTH.

Test Plan:
- Reset, then read 0x15; mem_ack with mem_rdata=0xDEADBEEF after 3 cycles -> mem_addr=0x15, mem_we=0; cpu_done one cycle after ack with cpu_hit=0, cpu_rdata=0xDEADBEEF; miss_cnt=1.
- Repeat read 0x15 -> cpu_done at C+2, cpu_hit=1, rdata=0xDEADBEEF, mem_req never rises; hit_cnt=1.
- Write 0x15=0x12345678 (hit), ack, then read 0x15 -> mem_we=1, mem_wdata=0x12345678; the read hits and returns 0x12345678.
- Read 0x0D (same index 5, tag differs) -> miss, line refilled. A following read of 0x15 misses again (eviction).
- Write miss to 0x22, then read 0x22 -> the write does not allocate; the read misses.
- Assert reset while in MEM_RD with mem_req=1, then pulse mem_ack -> no cpu_done, mem_req=0, all valids cleared, counters=0; the next read of 0x15 misses.
